dr_push_tx: RTL and testbench
=============================

Name: dr_push_tx

Overview:
- Clocked-domain transmitter for a Teak 4-phase dual-rail push channel: the producer end of a `<name>_0r0/_0r1/_0a` port on a synthesised Teak module (e.g. `x`, `coefs_N` of `teak_Poly_eval`).
- Buffers words arriving on a synchronous valid/ready interface and drives each one as a dual-rail codeword.
- Waits for the asynchronous acknowledge, returns to spacer, and waits for acknowledge release.
- Replaces hand-written bench driver processes and lets synchronous logic feed Teak netlists.

Parameters:
- WIDTH, 32, data bits per channel word.
- ADDR_W, 2, FIFO address bits; depth = 2**ADDR_W.
- CNT_W, 16, width of transfer counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- in_data  in  WIDTH  word to send.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready.
- ch_0r0  out  WIDTH  false rails.
- ch_0r1  out  WIDTH  true rails.
- ch_0a  in  1  asynchronous acknowledge from Teak module.
- busy  out  1  FIFO non-empty or handshake in progress.
- tx_count  out  CNT_W  completed 4-phase transfers, wraps at 2**CNT_W.
- proto_err  out  1  sticky: ch_0a seen high while channel idle at spacer.

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset_n=0 at a rising edge) forces:
  - ch_0r0 = ch_0r1 = 0 (spacer).
  - FIFO empty; in_ready = 1 after reset released.
  - tx_count = 0, proto_err = 0, busy = 0.
  - FSM to S_IDLE; synchroniser flops cleared.
- Reset mid-handshake drops the codeword immediately. The bench must hold ch_0a low before the next transfer; otherwise proto_err sets.
- ch_0a passes through a 2-flop synchroniser; ack_s is the second flop. All decisions use ack_s only.
- All outputs are registered, so rails never glitch. ch_0r0 and ch_0r1 change only on FSM transitions.
- FIFO:
  - in_ready = ~full, combinational from occupancy.
  - Push when in_valid & in_ready. Pop on S_DATA->S_RTZ.
  - Simultaneous push and pop: occupancy unchanged. Allowed only when not full; a word cannot be pushed into the slot being popped in the same cycle.
  - Pointers wrap modulo depth; occupancy is ADDR_W+1 bits.
- FSM:
  - S_IDLE, rails spacer:
    - If ack_s = 1: set proto_err and stay in S_IDLE.
    - Else if FIFO non-empty: load ch_0r1 = head, ch_0r0 = ~head, go to S_DATA.
  - S_DATA, codeword held stable: when ack_s = 1, set rails to 0, pop FIFO, increment tx_count, go to S_RTZ.
  - S_RTZ, spacer: when ack_s = 0, go to S_IDLE.
- Every rail pair is exactly one-hot in S_DATA and all-zero otherwise. Never drive both rails high.
- Latency: word pushed at edge t is visible on the rails after edge t+2 if the FSM is idle and ack_s = 0.
- Minimum per-word cycle time: 2 sync delays for ack rise + 2 for ack fall + 2 FSM edges, i.e. about 6 clk cycles.
- busy = (occupancy != 0) | (state != S_IDLE).
- tx_count wraps to 0 after all-ones; no saturation.
- Back-to-back words do not skip S_RTZ; each word completes a full 4-phase cycle.
- proto_err clears only on reset.

Test Plan:
- Single word: push 0x00000002, respond with ch_0a after 3 cycles. Expect ch_0r1 = 0x00000002 and ch_0r0 = 0xFFFFFFFD two edges after the push. Rails return to 0 within 3 cycles of ack rise; tx_count = 1; busy falls after ack release.
- Fill and drain: with ch_0a held low, push 5 words (0x1..0x5) into depth 4. Expect in_ready = 0 after the 4th push. Word 0x5 is accepted only after the first pop. Output order is 1,2,3,4,5; tx_count = 5.
- Simultaneous push/pop: with occupancy 2, push on the same edge as a pop. Occupancy stays 2 and order is preserved.
- Slow ack: hold ch_0a low for 50 cycles after the codeword appears. Rails stay constant, no pop occurs, and tx_count is unchanged.
- Protocol error: raise ch_0a while idle and empty. proto_err = 1 three edges later and no rails change. It stays set after ch_0a falls until reset_n pulses low.
- Reset mid-transfer: assert reset_n = 0 during S_DATA. The next edge gives rails = 0, in_ready = 1, tx_count = 0, and FIFO empty.

Source files
------------

// File: rtl/dr_push_tx.sv
// dr_push_tx: clocked producer for a Teak 4-phase dual-rail push channel.
// Buffers valid/ready words in a small FIFO and drives them as codewords.
module dr_push_tx #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ch_0r0,
    output logic [WIDTH-1:0] ch_0r1,
    input  logic             ch_0a,
    output logic             busy,
    output logic [CNT_W-1:0] tx_count,
    output logic             proto_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RTZ  = 2'd2
    } state_t;

    logic             ack_meta_q;
    logic             ack_s_q;

    logic [WIDTH-1:0] mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]  count_q, count_d;
    logic             avail_q, avail_d;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r0_q, r0_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic             proto_err_q, proto_err_d;
    logic             busy_q, busy_d;

    logic             full;
    logic             push;
    logic             pop;

    // Occupancy MSB alone marks a full FIFO (count == 2**ADDR_W).
    assign full     = count_q[ADDR_W];
    assign in_ready = ~full;
    assign push     = in_valid & ~full;

    assign ch_0r0    = r0_q;
    assign ch_0r1    = r1_q;
    assign busy      = busy_q;
    assign tx_count  = tx_count_q;
    assign proto_err = proto_err_q;

    // Handshake sequencing; rails only change on state transitions.
    always_comb begin
        state_d     = state_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        pop         = 1'b0;
        tx_count_d  = tx_count_q;
        proto_err_d = proto_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (ack_s_q) begin
                    proto_err_d = 1'b1;
                end else if (avail_q) begin
                    r1_d    = mem_q[rd_ptr_q];
                    r0_d    = ~mem_q[rd_ptr_q];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (ack_s_q) begin
                    r0_d       = '0;
                    r1_d       = '0;
                    pop        = 1'b1;
                    tx_count_d = tx_count_q + 1'b1;
                    state_d    = S_RTZ;
                end
            end
            S_RTZ: begin
                if (!ack_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                r0_d    = '0;
                r1_d    = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update; push and pop may coincide.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Availability is staged one cycle, so a new word reaches the
        // rails two edges after its push and the head read is settled.
        avail_d = (count_q != '0);
        busy_d  = (count_d != '0) || (state_d != S_IDLE);
    end

    // Word storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // State, rails, counters and the two-flop ack synchroniser.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            avail_q     <= 1'b0;
            state_q     <= S_IDLE;
            r0_q        <= '0;
            r1_q        <= '0;
            tx_count_q  <= '0;
            proto_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack_meta_q  <= ch_0a;
            ack_s_q     <= ack_meta_q;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            avail_q     <= avail_d;
            state_q     <= state_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            tx_count_q  <= tx_count_d;
            proto_err_q <= proto_err_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_dr_push_tx.sv
// tb_dr_push_tx: randomised bench for dr_push_tx with a queue-based model
// of the 4-phase push channel and a per-cycle compare process.
module tb_dr_push_tx;

    logic        clk;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ch_0r0;
    logic [31:0] ch_0r1;
    logic        ch_0a;
    logic        busy;
    logic [15:0] tx_count;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;
    bit auto_ack = 0;

    dr_push_tx dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_0r0    (ch_0r0),
        .ch_0r1    (ch_0r1),
        .ch_0a     (ch_0a),
        .busy      (busy),
        .tx_count  (tx_count),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: words queue with push edge stamps, ack seen
    // through two sample delays, one handshake phase variable.
    logic [31:0] mq[$];
    longint      mt[$];
    longint      edge_n = 0;
    int          m_phase = 0;
    bit          m_s1 = 0, m_s2 = 0;
    logic [31:0] m_r0 = 0, m_r1 = 0;
    logic [15:0] m_tx = 0;
    bit          m_err = 0;
    bit          m_busy = 0;

    always @(posedge clk) begin
        bit s2_old;
        int pre_size;
        edge_n++;
        s2_old = m_s2;
        if (!reset_n) begin
            mq.delete();
            mt.delete();
            m_phase = 0;
            m_r0 = 0;
            m_r1 = 0;
            m_tx = 0;
            m_err = 0;
            m_s1 = 0;
            m_s2 = 0;
        end else begin
            pre_size = mq.size();
            if (m_phase == 0) begin
                if (s2_old) m_err = 1;
                else if (mq.size() != 0 && mt[0] <= edge_n - 2) begin
                    m_r1 = mq[0];
                    m_r0 = ~mq[0];
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (s2_old) begin
                    m_r0 = 0;
                    m_r1 = 0;
                    void'(mq.pop_front());
                    void'(mt.pop_front());
                    m_tx = m_tx + 16'd1;
                    m_phase = 2;
                end
            end else begin
                if (!s2_old) m_phase = 0;
            end
            if (in_valid && pre_size < 4) begin
                mq.push_back(in_data);
                mt.push_back(edge_n);
            end
            m_s2 = m_s1;
            m_s1 = ch_0a;
        end
        m_busy = (mq.size() != 0) || (m_phase != 0);
    end

    // Per-cycle comparison against the model, plus codeword capture.
    logic [31:0] cap[$];
    bit          prev_cw = 0;

    always @(negedge clk) begin
        bit cw;
        if (chk_en) begin
            chk("ch_0r0", ch_0r0, m_r0);
            chk("ch_0r1", ch_0r1, m_r1);
            chk("in_ready", in_ready, (mq.size() < 4));
            chk("busy", busy, m_busy);
            chk("tx_count", tx_count, m_tx);
            chk("proto_err", proto_err, m_err);
            chk("rails_not_both", ch_0r0 & ch_0r1, 0);
            cw = &(ch_0r0 | ch_0r1);
            if (cw && !prev_cw) cap.push_back(ch_0r1);
            prev_cw = cw;
        end
    end

    // Teak-side responder: random delay before each ack edge.
    initial begin
        int cnt = 0;
        int dly = 0;
        bit cw;
        bit sp;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack) begin
                cw = &(ch_0r0 | ch_0r1);
                sp = ((ch_0r0 | ch_0r1) == 32'd0);
                if ((cw && !ch_0a) || (sp && ch_0a)) begin
                    if (cnt >= dly) begin
                        ch_0a = ~ch_0a;
                        cnt = 0;
                        dly = $urandom_range(0, 4);
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    task automatic drain(input int max);
        int k = 0;
        auto_ack = 1;
        while ((busy || ch_0a) && k < max) begin
            step();
            k++;
        end
        chk("drain_timeout", busy, 0);
    endtask

    task automatic wait_cw(input int max);
        int k = 0;
        while (!(&(ch_0r0 | ch_0r1)) && k < max) begin
            step();
            k++;
        end
        chk("codeword_timeout", &(ch_0r0 | ch_0r1), 1);
    endtask

    task automatic check_order(input logic [31:0] exp[$]);
        chk("order_len", cap.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap.size(); i++)
            chk("order_word", cap[i], exp[i]);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] held;
        logic [15:0] tx0;
        bit          done;
        reset_n  = 0;
        in_data  = 0;
        in_valid = 0;
        ch_0a    = 0;
        step();
        chk_en = 1;
        step();
        step();
        reset_n = 1;
        chk("rst_rail0", ch_0r0, 0);
        chk("rst_rail1", ch_0r1, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tx", tx_count, 0);
        chk("rst_err", proto_err, 0);

        // Single word with a hand-driven ack.
        in_data = 32'h2;
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        chk("lat_t1_rail1", ch_0r1, 0);
        step();
        chk("single_rail1", ch_0r1, 32'h00000002);
        chk("single_rail0", ch_0r0, 32'hFFFFFFFD);
        step();
        step();
        step();
        ch_0a = 1;
        step();
        step();
        chk("hold_rail1", ch_0r1, 32'h00000002);
        step();
        chk("rtz_rail1", ch_0r1, 0);
        chk("rtz_rail0", ch_0r0, 0);
        chk("single_tx", tx_count, 1);
        ch_0a = 0;
        step();
        step();
        step();
        chk("single_busy", busy, 0);

        // Fill and drain: 5 words into a depth-4 FIFO.
        cap.delete();
        for (int i = 1; i <= 4; i++) begin
            in_data = i;
            in_valid = 1;
            step();
        end
        chk("full_ready", in_ready, 0);
        in_data = 5;
        auto_ack = 1;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (in_ready) begin
                chk("w5_after_pop", tx_count, 2);
                done = 1;
            end
            step();
        end
        chk("w5_accept_timeout", done, 1);
        in_valid = 0;
        drain(400);
        chk("fill_tx", tx_count, 6);
        exp_q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        check_order(exp_q);

        // Push on the same edge as a pop with occupancy 2.
        auto_ack = 0;
        cap.delete();
        in_data = 32'hA;
        in_valid = 1;
        step();
        in_data = 32'hB;
        step();
        in_valid = 0;
        wait_cw(10);
        tx0 = tx_count;
        ch_0a = 1;
        step();
        step();
        in_data = 32'hC;
        in_valid = 1;
        step();
        in_valid = 0;
        chk("simul_tx", tx_count, tx0 + 16'd1);
        drain(200);
        exp_q = '{32'hA, 32'hB, 32'hC};
        check_order(exp_q);

        // Slow ack: codeword held with no pop.
        auto_ack = 0;
        in_data = 32'hDEADBEEF;
        in_valid = 1;
        step();
        in_valid = 0;
        wait_cw(10);
        held = ch_0r1;
        tx0 = tx_count;
        chk("slow_word", held, 32'hDEADBEEF);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("slow_rail", ch_0r1, held);
            chk("slow_tx", tx_count, tx0);
        end
        drain(100);

        // Random traffic with a random-latency responder.
        auto_ack = 1;
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data = $urandom;
            step();
        end
        in_valid = 0;
        drain(500);

        // Ack while idle and empty.
        auto_ack = 0;
        ch_0a = 1;
        step();
        step();
        chk("perr_early", proto_err, 0);
        step();
        chk("perr_set", proto_err, 1);
        chk("perr_rails", ch_0r1 | ch_0r0, 0);
        ch_0a = 0;
        repeat (5) step();
        chk("perr_sticky", proto_err, 1);
        reset_n = 0;
        step();
        reset_n = 1;
        chk("perr_clear", proto_err, 0);

        // Reset during S_DATA.
        in_data = 32'h11;
        in_valid = 1;
        step();
        in_data = 32'h22;
        step();
        in_valid = 0;
        wait_cw(10);
        reset_n = 0;
        step();
        chk("mid_rst_rail1", ch_0r1, 0);
        chk("mid_rst_rail0", ch_0r0, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_tx", tx_count, 0);
        chk("mid_rst_busy", busy, 0);
        reset_n = 1;
        cap.delete();
        in_data = 32'h33;
        in_valid = 1;
        step();
        in_valid = 0;
        drain(100);
        chk("post_rst_tx", tx_count, 1);
        exp_q = '{32'h33};
        check_order(exp_q);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
